// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and default sizes for the UART receive FIFO
package uart_rx_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 16;

    typedef struct packed {
        logic parity;
        logic frame;
    } err_tag_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - one write port, one registered read port storage array
module uart_fifo_ram #(
    parameter int W     = 34,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only loads on an accepted read, so it holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo_p.sv
// rtl/uart_rx_fifo_p.sv - UART receive FIFO with per-word error tags and sticky flags
module uart_rx_fifo_p
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int THRESH = DEPTH - 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_parity_err,
    input  logic                       wr_frame_err,
    input  logic                       rd_en,
    input  logic                       flush,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       parity_out,
    output logic                       frame_out,
    output logic                       data_err,
    output logic [$clog2(DEPTH)-1:0]   err_id,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       fifo_threshold,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 2;

    logic [AW-1:0] wptr, rptr, rd_idx, err_id_q;
    logic          rd_ok, wr_ok;
    err_tag_t      wr_tag, rd_tag;
    logic [EW-1:0] ram_wdata, ram_rdata;

    assign empty          = (count == '0);
    assign full           = (count == CW'(DEPTH));
    assign fifo_threshold = (count >= CW'(THRESH));

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign rd_ok = rd_en && !empty && !flush;
    assign wr_ok = wr_en && (!full || rd_ok) && !flush;

    assign wr_tag    = '{parity: wr_parity_err, frame: wr_frame_err};
    assign ram_wdata = {wr_tag, wr_data};

    uart_fifo_ram #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wptr),
        .wr_data (ram_wdata),
        .rd_en   (rd_ok),
        .rd_addr (rptr),
        .rd_data (ram_rdata)
    );

    assign rd_tag     = err_tag_t'(ram_rdata[DATA_W +: 2]);
    assign rd_data    = ram_rdata[DATA_W-1:0];
    assign parity_out = rd_tag.parity;
    assign frame_out  = rd_tag.frame;
    assign data_err   = rd_valid && (rd_tag.parity || rd_tag.frame);

    // err_id shows the index of the word in the errored rd_valid cycle itself.
    assign err_id = data_err ? rd_idx : err_id_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            rd_idx    <= '0;
            err_id_q  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (data_err) begin
                err_id_q <= rd_idx;
            end
            if (flush) begin
                wptr      <= '0;
                rptr      <= '0;
                count     <= '0;
                rd_valid  <= 1'b0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                rd_valid <= rd_ok;
                if (wr_ok) begin
                    wptr <= wptr + AW'(1);
                end
                if (rd_ok) begin
                    rptr   <= rptr + AW'(1);
                    rd_idx <= rptr;
                end
                case ({wr_ok, rd_ok})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (wr_en && full && !rd_ok) begin
                    overflow <= 1'b1;
                end
                if (rd_en && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_p.sv
// tb/tb_uart_rx_fifo_p.sv - self-checking bench for uart_rx_fifo_p
module tb_uart_rx_fifo_p;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int THRESH = 13;
    localparam int AW     = 4;
    localparam int CW     = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_parity_err = 1'b0;
    logic              wr_frame_err = 1'b0;
    logic              rd_en = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, parity_out, frame_out, data_err;
    logic [AW-1:0]     err_id;
    logic [CW-1:0]     count;
    logic              empty, full, fifo_threshold, overflow, underflow;

    uart_rx_fifo_p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_parity_err  (wr_parity_err),
        .wr_frame_err   (wr_frame_err),
        .rd_en          (rd_en),
        .flush          (flush),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .parity_out     (parity_out),
        .frame_out      (frame_out),
        .data_err       (data_err),
        .err_id         (err_id),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .fifo_threshold (fifo_threshold),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        p;
        logic        f;
        int          idx;
    } item_t;

    typedef struct {
        logic        we;
        logic [31:0] wd;
        logic        pe;
        logic        fe;
        logic        re;
        logic        fl;
        int          e_count;
        logic        e_empty;
        logic        e_full;
        logic        e_thr;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    item_t m_q[$];
    item_t exp_out[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    m_wptr, m_rptr, m_err_id;
    logic  m_ovf, m_unf, m_last_p, m_last_f, exp_valid;
    logic [31:0] m_last_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_out.delete();
        m_wptr = 0; m_rptr = 0; m_err_id = 0;
        m_ovf = 0; m_unf = 0; m_last_p = 0; m_last_f = 0; m_last_d = '0;
        exp_valid = 0;
    endtask

    task automatic check_outputs();
        item_t it;
        chk("rd_valid", rd_valid, exp_valid);
        if (rd_valid) begin
            if (exp_out.size() == 0) begin
                chk("sb_unexpected_read", 1, 0);
            end else begin
                it = exp_out.pop_front();
                m_last_d = it.d; m_last_p = it.p; m_last_f = it.f;
                if (it.p || it.f) m_err_id = it.idx;
            end
        end
        exp_out.delete();
        chk("data_err", data_err, exp_valid && (m_last_p || m_last_f));
        chk("rd_data", rd_data, m_last_d);
        chk("parity_out", parity_out, m_last_p);
        chk("frame_out", frame_out, m_last_f);
        chk("err_id", err_id, m_err_id);
        chk("count", count, m_q.size());
        chk("empty", empty, m_q.size() == 0);
        chk("full", full, m_q.size() == DEPTH);
        chk("fifo_threshold", fifo_threshold, m_q.size() >= THRESH);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    task automatic cyc(input logic we, input logic [31:0] wd, input logic pe, input logic fe,
                       input logic re, input logic fl);
        bit    rd_acc, wr_acc;
        item_t it;
        wr_en = we; wr_data = wd; wr_parity_err = pe; wr_frame_err = fe; rd_en = re; flush = fl;
        rd_acc = re && !fl && (m_q.size() != 0);
        wr_acc = we && !fl && ((m_q.size() < DEPTH) || rd_acc);
        exp_valid = rd_acc;
        if (fl) begin
            m_q.delete(); m_wptr = 0; m_rptr = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (we && m_q.size() == DEPTH && !rd_acc) m_ovf = 1;
            if (re && m_q.size() == 0) m_unf = 1;
            if (rd_acc) begin
                exp_out.push_back(m_q.pop_front());
                m_rptr = (m_rptr + 1) % DEPTH;
            end
            if (wr_acc) begin
                it.d = wd; it.p = pe; it.f = fe; it.idx = m_wptr;
                m_q.push_back(it);
                m_wptr = (m_wptr + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 32'h0,  0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
        vecs[1] = '{0, 32'h0,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        vecs[2] = '{1, 32'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 32'h22, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        vecs[4] = '{0, 32'h0,  0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[5] = '{1, 32'h33, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1};
        vecs[6] = '{0, 32'h0,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0};

        model_reset();
        #12;
        check_outputs();
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cyc(vecs[i].we, vecs[i].wd, vecs[i].pe, vecs[i].fe, vecs[i].re, vecs[i].fl);
            chk($sformatf("vec%0d count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d empty", i), empty, vecs[i].e_empty);
            chk($sformatf("vec%0d full", i), full, vecs[i].e_full);
            chk($sformatf("vec%0d thr", i), fifo_threshold, vecs[i].e_thr);
            chk($sformatf("vec%0d ovf", i), overflow, vecs[i].e_ovf);
            chk($sformatf("vec%0d unf", i), underflow, vecs[i].e_unf);
        end

        // Threshold, full, overflow and an errored word at index 4.
        for (int i = 0; i < 16; i++) begin
            cyc(1, (i == 4) ? 32'hA5 : 32'h100 + i, 0, (i == 4), 0, 0);
            if (i == 11) chk("thr_at_12", fifo_threshold, 0);
            if (i == 12) begin
                chk("thr_at_13", fifo_threshold, 1);
                chk("full_at_13", full, 0);
            end
        end
        cyc(1, 32'hDEAD, 0, 0, 0, 0);
        chk("full_17th", full, 1);
        chk("overflow_17th", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            if (i == 4) begin
                chk("a5_valid", rd_valid, 1);
                chk("a5_data", rd_data, 32'hA5);
                chk("a5_data_err", data_err, 1);
                chk("a5_frame", frame_out, 1);
                chk("a5_err_id", err_id, 4);
            end
        end
        cyc(0, 0, 0, 0, 1, 0);
        chk("empty_rd_unf", underflow, 1);
        chk("empty_rd_valid", rd_valid, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("flush_unf", underflow, 0);
        chk("flush_count", count, 0);

        // Offset pointers, fill, then streaming read+write across the wrap.
        for (int i = 0; i < 3; i++) cyc(1, 32'h50 + i, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) cyc(1, 32'h200 + i, (i % 5) == 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h300 + i, 0, (i % 7) == 3, 1, 0);
            chk("stream_count", count, 16);
        end
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("drained_empty", empty, 1);
        chk("no_overflow", overflow, 0);

        // Reset in the middle of a burst.
        for (int i = 0; i < 8; i++) cyc(1, 32'h400 + i, (i == 0), 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("pre_reset_count", count, 7);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_thr", fifo_threshold, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_parity", parity_out, 0);
        chk("rst_err_id", err_id, 0);
        #2;
        reset = 1'b1;
        wr_en = 0; rd_en = 0; flush = 0;
        cyc(1, 32'h55, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("post_rst_data", rd_data, 32'h55);
        chk("post_rst_err_id", err_id, 0);
        chk("post_rst_data_err", data_err, 1);
        cyc(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
